// File: rtl/mips_dmem_mmio_if.sv
// Core data-port and TX stream bundle for the MIPS data-memory / MMIO subsystem.
// master drives the core access and the sink's ready; slave is the memory subsystem.
interface mips_dmem_mmio_if;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;

  modport master (
    output memwrite, memaddr, writedata, tx_ready,
    input  readdata, tx_valid, tx_data
  );

  modport slave (
    input  memwrite, memaddr, writedata, tx_ready,
    output readdata, tx_valid, tx_data
  );
endinterface

// File: rtl/mips_dmem_mmio.sv
// Data RAM plus MMIO window (cycle counter, TX FIFO, status) behind the core's
// single-cycle load/store port. Loads are combinational; all state moves on rising clk.
module mips_dmem_mmio #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input logic             clk,
  input logic             rst,
  mips_dmem_mmio_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    REG_CYCLE  = 2'd0,
    REG_TXDATA = 2'd1,
    REG_STATUS = 2'd2,
    REG_RSVD   = 2'd3
  } reg_e;

  logic [31:0] ram  [DEPTH_WORDS];
  logic [31:0] fifo [FIFO_DEPTH];

  logic [31:0]   cycle;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic          overflow, unmapped_err;

  logic          ram_hit, mmio_hit;
  logic [AW-1:0] ram_idx;
  reg_e          sel;
  logic          full, cycle_we, push_req, push, pop, status_we, unmapped_we;

  assign ram_hit  = (bus.memaddr[31:AW+2] == '0);
  assign mmio_hit = (bus.memaddr[31:4] == MMIO_BASE[31:4]);
  assign ram_idx  = bus.memaddr[AW+1:2];
  assign sel      = reg_e'(bus.memaddr[3:2]);

  assign full        = (count == FULL_COUNT);
  assign cycle_we    = bus.memwrite && mmio_hit && (sel == REG_CYCLE);
  assign push_req    = bus.memwrite && mmio_hit && (sel == REG_TXDATA);
  assign status_we   = bus.memwrite && mmio_hit && (sel == REG_STATUS);
  assign unmapped_we = bus.memwrite && !ram_hit && !mmio_hit;
  assign push        = push_req && !full;
  assign pop         = bus.tx_valid && bus.tx_ready;

  // NOTE: the RAM array has no reset branch so it maps onto plain memory; loads see the
  // pre-edge word because the write lands at the edge while the read is combinational.
  always_ff @(posedge clk) begin
    if (bus.memwrite && ram_hit) ram[ram_idx] <= bus.writedata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo[i] <= '0;
    end else if (push) begin
      fifo[wr_ptr] <= bus.writedata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      cycle <= cycle_we ? bus.writedata : cycle + 32'd1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Software clear of the sticky flags wins over any set in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow     <= 1'b0;
      unmapped_err <= 1'b0;
    end else if (status_we) begin
      overflow     <= 1'b0;
      unmapped_err <= 1'b0;
    end else begin
      if (push_req && full) overflow     <= 1'b1;
      if (unmapped_we)      unmapped_err <= 1'b1;
    end
  end

  assign bus.tx_valid = (count != '0);
  assign bus.tx_data  = fifo[rd_ptr];

  // NOTE: readdata gets a default first so no path through the decode infers a latch.
  always_comb begin
    bus.readdata = '0;
    if (ram_hit) begin
      bus.readdata = ram[ram_idx];
    end else if (mmio_hit) begin
      case (sel)
        REG_CYCLE:  bus.readdata = cycle;
        REG_STATUS: bus.readdata = {16'h0, 8'(count), 5'h0, unmapped_err, overflow, full};
        default:    bus.readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_dmem_mmio.sv
// Bench for mips_dmem_mmio: directed vector table, reset sequences, then random
// traffic checked against a queue/array reference model.
module tb_mips_dmem_mmio;

  localparam logic [31:0] MMIO   = 32'hFFFF_0000;
  localparam logic [31:0] A_CYC  = 32'hFFFF_0000;
  localparam logic [31:0] A_TX   = 32'hFFFF_0004;
  localparam logic [31:0] A_STAT = 32'hFFFF_0008;
  localparam logic [31:0] A_RSVD = 32'hFFFF_000C;
  localparam int          FDEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_dmem_mmio_if bus ();

  mips_dmem_mmio #(
    .DEPTH_WORDS(256),
    .FIFO_DEPTH (FDEPTH),
    .MMIO_BASE  (MMIO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          ready;
    bit          chk_rd;
    logic [31:0] exp_rd;
    bit          chk_tx;
    bit          exp_valid;
    logic [31:0] exp_txd;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_ram [int];
  logic [31:0] m_fifo [$];
  logic [31:0] m_cycle;
  bit          m_ovf, m_unm;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_ram(input logic [31:0] a);
    return a < 32'd1024;
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return a[31:4] == MMIO[31:4];
  endfunction

  function automatic bit model_rd(input logic [31:0] a, output logic [31:0] v);
    logic [1:0] s;
    s = a[3:2];
    v = '0;
    if (is_ram(a)) begin
      if (!m_ram.exists(int'(a[9:2]))) return 1'b0;
      v = m_ram[int'(a[9:2])];
    end else if (is_mmio(a)) begin
      if (s == 2'd0) v = m_cycle;
      else if (s == 2'd2)
        v = {16'h0, 8'(m_fifo.size()), 5'h0, m_unm, m_ovf, m_fifo.size() == FDEPTH};
    end
    return 1'b1;
  endfunction

  function automatic void model_reset();
    m_cycle = '0;
    m_fifo.delete();
    m_ram.delete();
    m_ovf = 1'b0;
    m_unm = 1'b0;
  endfunction

  function automatic void model_step(input vec_t v);
    bit mm, was_full, ovf_set, unm_set;
    logic [1:0] s;
    mm       = is_mmio(v.addr);
    s        = v.addr[3:2];
    was_full = (m_fifo.size() == FDEPTH);
    ovf_set  = 1'b0;
    unm_set  = v.we && !is_ram(v.addr) && !mm;
    if (v.we && mm && s == 2'd0) m_cycle = v.wdata;
    else m_cycle = m_cycle + 32'd1;
    if (v.we && is_ram(v.addr)) m_ram[int'(v.addr[9:2])] = v.wdata;
    if (m_fifo.size() != 0 && v.ready) void'(m_fifo.pop_front());
    if (v.we && mm && s == 2'd1) begin
      if (was_full) ovf_set = 1'b1;
      else m_fifo.push_back(v.wdata);
    end
    if (v.we && mm && s == 2'd2) begin
      m_ovf = 1'b0;
      m_unm = 1'b0;
    end else begin
      if (ovf_set) m_ovf = 1'b1;
      if (unm_set) m_unm = 1'b1;
    end
  endfunction

  // Called at a falling edge; checks settle 1 ns later, model advances at the rising edge.
  task automatic apply(input vec_t v);
    logic [31:0] exp;
    bus.memwrite  = v.we;
    bus.memaddr   = v.addr;
    bus.writedata = v.wdata;
    bus.tx_ready  = v.ready;
    #1;
    if (model_rd(v.addr, exp)) check("readdata_model", bus.readdata, exp);
    check("tx_valid_model", 32'(bus.tx_valid), 32'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) check("tx_data_model", bus.tx_data, m_fifo[0]);
    if (v.chk_rd) check($sformatf("readdata_vec@%h", v.addr), bus.readdata, v.exp_rd);
    if (v.chk_tx) begin
      check("tx_valid_vec", 32'(bus.tx_valid), 32'(v.exp_valid));
      if (v.exp_valid) check("tx_data_vec", bus.tx_data, v.exp_txd);
    end
    @(posedge clk);
    model_step(v);
    @(negedge clk);
  endtask

  // Asserts reset mid-cycle, checks the asynchronous effect, releases on a falling edge.
  task automatic do_reset();
    bus.memwrite = 1'b0;
    bus.memaddr  = A_STAT;
    bus.tx_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_tx_data", bus.tx_data, 32'd0);
    check("rst_status", bus.readdata, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                              input bit ready, input bit chk_rd, input logic [31:0] exp_rd,
                              input bit exp_valid, input logic [31:0] exp_txd);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.ready = ready;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd;
    v.chk_tx = 1'b1; v.exp_valid = exp_valid; v.exp_txd = exp_txd;
    return v;
  endfunction

  vec_t vecs [$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    int   r;

    // Directed table: cycle counter, RAM, FIFO fill/overflow/drain, push+pop, unmapped store
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, A_CYC, 0, 0, 1, 32'(i), 0, 0));
    vecs.push_back(mk(1, A_CYC, 32'hFFFF_FFFE, 0, 1, 32'd5, 0, 0));
    vecs.push_back(mk(0, A_CYC, 0, 0, 1, 32'hFFFF_FFFE, 0, 0));
    vecs.push_back(mk(0, A_CYC, 0, 0, 1, 32'hFFFF_FFFF, 0, 0));
    vecs.push_back(mk(0, A_CYC, 0, 0, 1, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h10, 0, 0, 1, 32'hDEAD_BEEF, 0, 0));
    vecs.push_back(mk(0, 32'h13, 0, 0, 1, 32'hDEAD_BEEF, 0, 0));
    vecs.push_back(mk(1, A_TX, 32'hA0, 0, 1, 0, 0, 0));
    for (int i = 1; i < 5; i++) vecs.push_back(mk(1, A_TX, 32'hA0 + 32'(i), 0, 1, 0, 1, 32'hA0));
    vecs.push_back(mk(0, A_STAT, 0, 0, 1, 32'h0403, 1, 32'hA0));
    vecs.push_back(mk(0, A_STAT, 0, 1, 1, 32'h0403, 1, 32'hA0));
    vecs.push_back(mk(0, A_STAT, 0, 1, 1, 32'h0302, 1, 32'hA1));
    vecs.push_back(mk(0, A_STAT, 0, 1, 1, 32'h0202, 1, 32'hA2));
    vecs.push_back(mk(0, A_STAT, 0, 1, 1, 32'h0102, 1, 32'hA3));
    vecs.push_back(mk(1, A_STAT, 32'h5A5A, 1, 1, 32'h0002, 0, 0));
    vecs.push_back(mk(0, A_STAT, 0, 0, 1, 32'h0000, 0, 0));
    vecs.push_back(mk(1, A_TX, 32'hB0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, A_TX, 32'hB1, 0, 1, 0, 1, 32'hB0));
    vecs.push_back(mk(1, A_TX, 32'hB2, 1, 1, 0, 1, 32'hB0));
    vecs.push_back(mk(0, A_STAT, 0, 0, 1, 32'h0200, 1, 32'hB1));
    vecs.push_back(mk(1, A_TX, 32'hB3, 0, 1, 0, 1, 32'hB1));
    vecs.push_back(mk(1, A_TX, 32'hB4, 0, 1, 0, 1, 32'hB1));
    vecs.push_back(mk(1, A_TX, 32'hB5, 1, 1, 0, 1, 32'hB1));
    vecs.push_back(mk(0, A_STAT, 0, 0, 1, 32'h0302, 1, 32'hB2));
    vecs.push_back(mk(1, 32'h8000_0000, 32'h1234_5678, 0, 1, 0, 1, 32'hB2));
    vecs.push_back(mk(0, A_STAT, 0, 0, 1, 32'h0306, 1, 32'hB2));
    vecs.push_back(mk(0, 32'h10, 0, 0, 1, 32'hDEAD_BEEF, 1, 32'hB2));
    vecs.push_back(mk(1, A_RSVD, 32'hFFFF_FFFF, 0, 1, 0, 1, 32'hB2));
    vecs.push_back(mk(0, A_STAT, 0, 0, 1, 32'h0306, 1, 32'hB2));

    // Power-on reset
    rst           = 1'b1;
    bus.memwrite  = 1'b0;
    bus.memaddr   = A_STAT;
    bus.writedata = '0;
    bus.tx_ready  = 1'b0;
    model_reset();
    #1;
    check("por_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("por_tx_data", bus.tx_data, 32'd0);
    check("por_status", bus.readdata, 32'd0);
    bus.memaddr = A_CYC;
    #1;
    check("por_cycle", bus.readdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) apply(vecs[i]);

    // Reset while the FIFO still holds B2..B4
    do_reset();
    apply(mk(0, A_STAT, 0, 0, 1, 32'h0, 0, 0));
    apply(mk(0, A_CYC, 0, 0, 1, 32'h1, 0, 0));

    // Random traffic against the model, with one more reset in the middle
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      r = $urandom_range(0, 9);
      rv.we     = ($urandom_range(0, 1) == 1);
      rv.wdata  = $urandom;
      rv.ready  = ($urandom_range(0, 2) == 0);
      rv.chk_rd = 1'b0;
      rv.exp_rd = '0;
      rv.chk_tx = 1'b0;
      rv.exp_valid = 1'b0;
      rv.exp_txd   = '0;
      if (r < 4)       rv.addr = 32'($urandom_range(0, 63));
      else if (r < 8)  rv.addr = MMIO | 32'($urandom_range(0, 15));
      else if (r == 8) rv.addr = 32'd1024 + 32'($urandom_range(0, 15));
      else             rv.addr = 32'h4000_0000 | 32'($urandom);
      apply(rv);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
